mem_refill_unit: RTL and testbench
==================================

# mem_refill_unit

Main-memory interface stage directly downstream of the cache controller FSM. Services the controller's read-miss state by fetching a full cache line word-by-word from main memory and writing it into the cache data/tag arrays, and services the write-through state by issuing a single-word memory write. Produces the `Data_ReadyM` (refill complete) and `Data_Ready` (write-through complete) handshakes the controller waits on.

## Interface
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: word width. Words are 4 bytes.
- `WORDS_PER_LINE`, 4: words per cache line; power of two, ≥2.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `refill_req`  in  1  level request for a line refill (controller in readMiss).
- `wt_req`  in  1  level request for a write-through (controller in writeThrough).
- `req_addr`  in  ADDR_W  byte address of the access.
- `wt_data`  in  DATA_W  write-through data.
- `mem_req`  out  1  memory request, held until acknowledged.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`.
- `mem_addr`  out  ADDR_W  word-aligned byte address (bits[1:0] = 0).
- `mem_wdata`  out  DATA_W  write data.
- `mem_ack`  in  1  one-cycle acknowledge; read data valid in the same cycle.
- `mem_rdata`  in  DATA_W  read data.
- `fill_we`  out  1  data-array write strobe.
- `fill_idx`  out  log2(WORDS_PER_LINE)  word index within the line.
- `fill_data`  out  DATA_W  word to write.
- `tag_we`  out  1  tag/valid update strobe for the line at `req_addr`.
- `busy`  out  1  high in any state other than IDLE.
- `Data_ReadyM`  out  1  one-cycle pulse: refill complete.
- `Data_Ready`  out  1  one-cycle pulse: write-through complete.

## Operation
- States: IDLE, FILL, FDONE, WT, WDONE. All outputs are registered.
- IDLE: samples the requests at each edge. `refill_req` → FILL, and `wt_req` → WT. When both are high, refill has priority. The block latches `req_addr` (and `wt_data` for WT) at the sampling edge. Requests arriving in any other state are ignored.
- FILL:
  - `mem_req`=1, `mem_we`=0.
  - `mem_addr` = line base (`req_addr` with low log2(WORDS_PER_LINE)+2 bits zeroed) + 4·idx.
  - On each `mem_ack`, at that edge:
    - capture `mem_rdata`;
    - set `fill_we`/`fill_idx`/`fill_data` for the following cycle;
    - advance idx modulo WORDS_PER_LINE;
    - `mem_req` stays high with the new address.
  - After the WORDS_PER_LINE-th ack → FDONE.
- FDONE, one cycle:
  - the last `fill_we` is high;
  - `tag_we`=1 and `Data_ReadyM`=1;
  - `mem_req`=0;
  - next state is IDLE.
- WT:
  - `mem_req`=1, `mem_we`=1.
  - `mem_addr` = latched address with bits[1:0] cleared.
  - `mem_wdata` = latched data.
  - On `mem_ack` → WDONE.
- WDONE, one cycle: `Data_Ready`=1, `mem_req`=0. Next state is IDLE.
- `mem_ack` is ignored in IDLE, FDONE and WDONE.
- Reset (asynchronous, `reset`=0): state IDLE and idx 0. Every output is 0, including `mem_addr`, `mem_wdata`, `fill_idx` and `fill_data`.
- Reset asserted mid-transaction:
  - `mem_req` drops immediately;
  - the partial line is abandoned;
  - `tag_we` is not issued, so the line stays invalid.

## Timing
- Request sampled at the end of IDLE cycle t0 → `mem_req` high from t0+1.
- Refill with zero-wait memory (ack every cycle):
  - acks in t0+1 … t0+W;
  - `fill_we` in t0+2 … t0+W+1;
  - `Data_ReadyM` in t0+W+1;
  - IDLE at t0+W+2.
- Each wait cycle on `mem_ack` adds one cycle.
- Write-through, zero-wait: ack in t0+1, `Data_Ready` in t0+2, IDLE at t0+3.
- The controller leaves its request state on the completion pulse, so the request is low by the IDLE cycle that follows. No re-trigger occurs.
- Back-to-back transactions: the minimum gap is one IDLE cycle.

## Configuration
- `CRITICAL_WORD_FIRST_EN` defined:
  - FILL starts at the word index of `req_addr` (bits[log2(W)+1:2]) and wraps modulo W. Example, W=4 and index 2: order is 2,3,0,1.
  - Still exactly W words, and `Data_ReadyM` timing is unchanged.
- Undefined: FILL always starts at index 0 and ascends.

## Test plan
- Reset mid-FILL:
  - Stimulus: pull `reset` low after 2 acks.
  - Required: `mem_req`, `fill_we`, `busy`, `Data_ReadyM` and `tag_we` are 0 immediately, with no `tag_we` afterwards.
  - Required: the next refill starts from idx 0, or from the critical word with the macro defined.
- Refill with zero-wait memory:
  - Stimulus: `refill_req`=1, `req_addr`=0x0000_1034, W=4, memory returns 0xA0+idx.
  - Required: `mem_addr` sequence 0x1030, 0x1034, 0x1038, 0x103C.
  - Required: `fill_idx` 0..3 with data 0xA0..0xA3, and `Data_ReadyM` exactly one pulse 5 cycles after sampling.
- Same stimulus with `CRITICAL_WORD_FIRST_EN` defined:
  - Required: address order 0x1034, 0x1038, 0x103C, 0x1030.
  - Required: `fill_idx` order 1, 2, 3, 0.
- Write-through with 3 wait cycles:
  - Stimulus: `wt_req`=1, `req_addr`=0x2002, `wt_data`=0xDEADBEEF; `mem_ack` arrives 3 cycles late.
  - Required: `mem_addr`=0x2000 and `mem_we`=1, held stable for 4 cycles.
  - Required: `Data_Ready` pulses once, and `fill_we`/`tag_we` stay 0 throughout.
- Simultaneous requests:
  - Stimulus: `refill_req` and `wt_req` both high in IDLE.
  - Required: a refill is performed; the write-through is serviced only if `wt_req` is still high at a later IDLE sample.
- Spurious `mem_ack` in IDLE:
  - Required: no state change and no strobes.

Source files
------------

// File: rtl/mem_refill_unit.sv
// mem_refill_unit: refills a cache line word-by-word from main memory and issues write-through stores
// Ports:
//   clk_i, rst_ni              clock (rising edge), asynchronous active-low reset
//   refill_req_i, wt_req_i     level requests from the cache controller (refill wins when both are high)
//   req_addr_i, wt_data_i      access byte address and write-through data, latched when a request is taken
//   mem_req_o/mem_we_o         memory request (held until mem_ack_i) and direction (1 = write)
//   mem_addr_o, mem_wdata_o    word-aligned memory address and write data
//   mem_ack_i, mem_rdata_i     one-cycle acknowledge with same-cycle read data
//   fill_we_o/fill_idx_o/fill_data_o  data-array write of one refilled word
//   tag_we_o                   tag/valid update once the whole line has arrived
//   busy_o                     high whenever not idle
//   Data_ReadyM_o, Data_Ready_o  one-cycle completion pulses for refill and write-through
// Build option: CRITICAL_WORD_FIRST_EN starts the refill at the requested word and wraps.
module mem_refill_unit #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              refill_req_i,
    input  logic                              wt_req_i,
    input  logic [ADDR_W-1:0]                 req_addr_i,
    input  logic [DATA_W-1:0]                 wt_data_i,
    output logic                              mem_req_o,
    output logic                              mem_we_o,
    output logic [ADDR_W-1:0]                 mem_addr_o,
    output logic [DATA_W-1:0]                 mem_wdata_o,
    input  logic                              mem_ack_i,
    input  logic [DATA_W-1:0]                 mem_rdata_i,
    output logic                              fill_we_o,
    output logic [$clog2(WORDS_PER_LINE)-1:0] fill_idx_o,
    output logic [DATA_W-1:0]                 fill_data_o,
    output logic                              tag_we_o,
    output logic                              busy_o,
    output logic                              Data_ReadyM_o,
    output logic                              Data_Ready_o
);
    localparam int IW = $clog2(WORDS_PER_LINE);
    localparam int LW = IW + 2;

    typedef enum logic [2:0] {IDLE, FILL, FDONE, WT, WDONE} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d, cnt_q, cnt_d, idx_nx, start;
    logic [ADDR_W-LW-1:0] line_q, line_d;
    logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d, fill_data_q, fill_data_d;
    logic                fill_we_q, fill_we_d, tag_we_q, tag_we_d, busy_q, busy_d;
    logic [IW-1:0]       fill_idx_q, fill_idx_d;
    logic                drm_q, drm_d, dr_q, dr_d;
    logic                unused_byte_bits;

    assign unused_byte_bits = ^req_addr_i[1:0];
    assign idx_nx = idx_q + 1'b1;

`ifdef CRITICAL_WORD_FIRST_EN
    assign start = req_addr_i[LW-1:2];
`else
    assign start = '0;
`endif

    // Every output is computed one cycle ahead from the next state so all of them come straight from flops.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        line_d      = line_q;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fill_we_d   = 1'b0;
        fill_idx_d  = fill_idx_q;
        fill_data_d = fill_data_q;
        tag_we_d    = 1'b0;
        drm_d       = 1'b0;
        dr_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (refill_req_i) begin
                    state_d    = FILL;
                    line_d     = req_addr_i[ADDR_W-1:LW];
                    idx_d      = start;
                    cnt_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {req_addr_i[ADDR_W-1:LW], start, 2'b00};
                end else if (wt_req_i) begin
                    state_d     = WT;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {req_addr_i[ADDR_W-1:2], 2'b00};
                    mem_wdata_d = wt_data_i;
                end
            end
            FILL: begin
                mem_req_d = 1'b1;
                if (mem_ack_i) begin
                    fill_we_d   = 1'b1;
                    fill_idx_d  = idx_q;
                    fill_data_d = mem_rdata_i;
                    idx_d       = idx_nx;
                    cnt_d       = cnt_q + 1'b1;
                    mem_addr_d  = {line_q, idx_nx, 2'b00};
                    // Word count is tracked apart from idx because idx may start mid-line and wrap.
                    if (cnt_q == IW'(WORDS_PER_LINE - 1)) begin
                        state_d   = FDONE;
                        mem_req_d = 1'b0;
                        tag_we_d  = 1'b1;
                        drm_d     = 1'b1;
                    end
                end
            end
            WT: begin
                mem_req_d = 1'b1;
                mem_we_d  = 1'b1;
                if (mem_ack_i) begin
                    state_d   = WDONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    dr_d      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            line_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            fill_we_q   <= 1'b0;
            fill_idx_q  <= '0;
            fill_data_q <= '0;
            tag_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            drm_q       <= 1'b0;
            dr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            fill_we_q   <= fill_we_d;
            fill_idx_q  <= fill_idx_d;
            fill_data_q <= fill_data_d;
            tag_we_q    <= tag_we_d;
            busy_q      <= busy_d;
            drm_q       <= drm_d;
            dr_q        <= dr_d;
        end
    end

    assign mem_req_o     = mem_req_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign fill_we_o     = fill_we_q;
    assign fill_idx_o    = fill_idx_q;
    assign fill_data_o   = fill_data_q;
    assign tag_we_o      = tag_we_q;
    assign busy_o        = busy_q;
    assign Data_ReadyM_o = drm_q;
    assign Data_Ready_o  = dr_q;
endmodule

// File: tb/tb_mem_refill_unit.sv
// tb_mem_refill_unit: scoreboard bench for mem_refill_unit (4-word lines, 32-bit address/data)
module tb_mem_refill_unit;
    logic        clk_i = 1'b0, rst_ni = 1'b1;
    logic        refill_req_i = 1'b0, wt_req_i = 1'b0;
    logic [31:0] req_addr_i = '0, wt_data_i = '0;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        fill_we_o;
    logic [1:0]  fill_idx_o;
    logic [31:0] fill_data_o;
    logic        tag_we_o, busy_o, Data_ReadyM_o, Data_Ready_o;

    mem_refill_unit dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .refill_req_i(refill_req_i), .wt_req_i(wt_req_i),
        .req_addr_i(req_addr_i), .wt_data_i(wt_data_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i), .fill_we_o(fill_we_o), .fill_idx_o(fill_idx_o),
        .fill_data_o(fill_data_o), .tag_we_o(tag_we_o), .busy_o(busy_o),
        .Data_ReadyM_o(Data_ReadyM_o), .Data_Ready_o(Data_Ready_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wd; } mem_t;
    typedef struct { logic [1:0] idx; logic [31:0] d; } fill_t;
    typedef struct { int kind; int cyc; } ev_t;

    mem_t  exp_mem[$];
    fill_t exp_fill[$];
    ev_t   exp_ev[$];

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int waits = 0;
    int wcnt = 0;
    bit spur = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: output seen with nothing expected (cycle %0d)", nm, cyc);
    endtask

    // Memory model: ack after 'waits' idle request cycles, read data is 0xA0 + word index.
    initial forever begin
        @(posedge clk_i);
        #2;
        mem_ack_i   = spur;
        mem_rdata_i = 32'hA0 + 32'(mem_addr_o[3:2]);
        if (mem_req_o) begin
            if (wcnt == waits) begin
                mem_ack_i = 1'b1;
                wcnt = 0;
            end else wcnt++;
        end
    end

    // Monitor: checks every DUT output event against the head of its queue.
    initial forever begin
        @(negedge clk_i);
        if (rst_ni) begin
            if (mem_req_o) begin
                if (exp_mem.size() == 0) flag("mem_req");
                else begin
                    chk("mem_addr", mem_addr_o, exp_mem[0].addr);
                    chk("mem_we", mem_we_o, exp_mem[0].we);
                    if (exp_mem[0].we) chk("mem_wdata", mem_wdata_o, exp_mem[0].wd);
                    if (mem_ack_i) void'(exp_mem.pop_front());
                end
            end
            if (fill_we_o) begin
                if (exp_fill.size() == 0) flag("fill_we");
                else begin
                    chk("fill_idx", fill_idx_o, exp_fill[0].idx);
                    chk("fill_data", fill_data_o, exp_fill[0].d);
                    void'(exp_fill.pop_front());
                end
            end
            if (Data_ReadyM_o || Data_Ready_o || tag_we_o) begin
                if (exp_ev.size() == 0) flag("completion");
                else begin
                    chk("pulse_kind", Data_ReadyM_o ? (tag_we_o ? 1 : 3) : (Data_Ready_o ? 2 : 4), exp_ev[0].kind);
                    chk("pulse_cycle", cyc, exp_ev[0].cyc);
                    void'(exp_ev.pop_front());
                end
            end
        end
    end

    task automatic push_refill(input logic [31:0] base, input int start, input int nm, input int nf);
        for (int k = 0; k < nm; k++) exp_mem.push_back('{base + 32'(4 * ((start + k) % 4)), 1'b0, 32'h0});
        for (int k = 0; k < nf; k++) exp_fill.push_back('{2'((start + k) % 4), 32'hA0 + 32'((start + k) % 4)});
    endtask

    task automatic wait_pulse(input bit want_m, output int seen, output int reqc);
        bit found = 1'b0;
        reqc = 0;
        seen = -1;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk_i);
            #1;
            if (mem_req_o) reqc++;
            if (want_m ? Data_ReadyM_o : Data_Ready_o) begin
                found = 1'b1;
                seen = cyc;
            end
        end
        if (!found) flag(want_m ? "timeout_Data_ReadyM" : "timeout_Data_Ready");
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_refill(input logic [31:0] a, input int start);
        int t0, seen, reqc;
        t0 = cyc;
        push_refill({a[31:4], 4'h0}, start, 4, 4);
        exp_ev.push_back('{1, t0 + 5});
        refill_req_i = 1'b1;
        req_addr_i = a;
        wait_pulse(1'b1, seen, reqc);
        refill_req_i = 1'b0;
        chk("refill_req_cycles", reqc, 4);
        idle(2);
    endtask

    initial begin
        int t0, seen, reqc;
        #2 rst_ni = 1'b0;
        idle(2);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_fill_we", fill_we_o, 0);
        chk("rst_fill_idx", fill_idx_o, 0);
        chk("rst_fill_data", fill_data_o, 0);
        chk("rst_tag_we", tag_we_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_Data_ReadyM", Data_ReadyM_o, 0);
        chk("rst_Data_Ready", Data_Ready_o, 0);
        rst_ni = 1'b1;
        idle(2);

        // Zero-wait refill of 0x1034: words 0..3, or 1,2,3,0 with critical-word-first.
        do_refill(32'h0000_1034, CWF ? 1 : 0);

        // Write-through with three wait cycles.
        waits = 3;
        t0 = cyc;
        exp_mem.push_back('{32'h0000_2000, 1'b1, 32'hDEADBEEF});
        exp_ev.push_back('{2, t0 + 5});
        wt_req_i = 1'b1;
        req_addr_i = 32'h0000_2002;
        wt_data_i = 32'hDEADBEEF;
        wait_pulse(1'b0, seen, reqc);
        wt_req_i = 1'b0;
        waits = 0;
        chk("wt_req_cycles", reqc, 4);
        idle(2);

        // Both requests high: refill first, write-through at the next idle sample.
        t0 = cyc;
        push_refill(32'h0000_1030, CWF ? 1 : 0, 4, 4);
        exp_ev.push_back('{1, t0 + 5});
        refill_req_i = 1'b1;
        wt_req_i = 1'b1;
        req_addr_i = 32'h0000_1034;
        wt_data_i = 32'h1234_5678;
        wait_pulse(1'b1, seen, reqc);
        refill_req_i = 1'b0;
        req_addr_i = 32'h0000_300B;
        exp_mem.push_back('{32'h0000_3008, 1'b1, 32'h1234_5678});
        exp_ev.push_back('{2, seen + 3});
        wait_pulse(1'b0, seen, reqc);
        wt_req_i = 1'b0;
        idle(2);

        // Spurious acks while idle must do nothing.
        spur = 1'b1;
        idle(3);
        spur = 1'b0;
        chk("spur_busy", busy_o, 0);
        idle(2);

        // Reset after two acks of a refill of 0x5008; the partial line is abandoned.
        t0 = cyc;
        push_refill(32'h0000_5000, CWF ? 2 : 0, 2, 1);
        refill_req_i = 1'b1;
        req_addr_i = 32'h0000_5008;
        idle(3);
        rst_ni = 1'b0;
        refill_req_i = 1'b0;
        #1;
        chk("mid_rst_mem_req", mem_req_o, 0);
        chk("mid_rst_fill_we", fill_we_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_Data_ReadyM", Data_ReadyM_o, 0);
        chk("mid_rst_tag_we", tag_we_o, 0);
        chk("mid_rst_mem_left", exp_mem.size(), 0);
        chk("mid_rst_fill_left", exp_fill.size(), 0);
        idle(2);
        rst_ni = 1'b1;
        idle(2);
        do_refill(32'h0000_5008, CWF ? 2 : 0);

        idle(3);
        chk("end_mem_left", exp_mem.size(), 0);
        chk("end_fill_left", exp_fill.size(), 0);
        chk("end_ev_left", exp_ev.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
